// File: rtl/operand_entry_pkg.sv
// operand_entry shared types: FSM stage encoding and default timing.
// Stage codes drive status LEDs directly, so values are fixed.
package operand_entry_pkg;

  typedef enum logic [1:0] {
    S_INS  = 2'd0,
    S_OP   = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES  = 1_000_000;
  localparam int DEF_LONGPRESS_CYCLES = 100_000_000;

endpackage

// File: rtl/operand_entry_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debounce,
// and a one-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES =
    operand_entry_pkg::DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  // Level flips only after a full run of disagreeing samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_s2 == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_level <= ~r_level;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/operand_entry.sv
// Operand/op capture stage ahead of the ALU, one button steps entry.
// Optional long-press clear: OPERAND_ENTRY_LONGPRESS_EN.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int LONGPRESS_CYCLES = DEF_LONGPRESS_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic [2:0] op_sw,
  input  logic       btn,
  output logic [7:0] ins,
  output logic [2:0] op,
  output logic       out_valid,
  output logic [1:0] stage
);

  if (DEBOUNCE_CYCLES < 2 || LONGPRESS_CYCLES < 2)
  begin : g_bad_cfg
    $error("operand_entry: cycle counts must be >= 2");
  end

  logic [7:0] r_sw_s1;
  logic [7:0] r_sw_s2;
  logic [2:0] r_op_s1;
  logic [2:0] r_op_s2;
  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_ins;
  logic [2:0] r_op;
  logic       r_valid;
  logic       w_level;
  logic       w_press_raw;
  logic       w_press;
  logic       w_long;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn),
    .o_level(w_level),
    .o_press(w_press_raw)
  );

  assign w_press = w_press_raw & w_level;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_op_s1 <= '0;
      r_op_s2 <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      r_op_s1 <= op_sw;
      r_op_s2 <= r_op_s1;
    end
  end

`ifdef OPERAND_ENTRY_LONGPRESS_EN
  localparam int HW = $clog2(LONGPRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_FIRE =
    HW'(LONGPRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT =
    HW'(LONGPRESS_CYCLES);

  logic [HW-1:0] r_hold;

  // Saturates one past the fire point so a hold clears once.
  always_ff @(posedge clk) begin
    if (!reset || !w_level) begin
      r_hold <= '0;
    end else if (r_hold != HOLD_SAT) begin
      r_hold <= r_hold + HW'(1);
    end
  end

  assign w_long = w_level && (r_hold == HOLD_FIRE);
`else
  assign w_long = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_INS;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OP:    w_next = w_press ? S_SHOW : S_OP;
      S_SHOW:  w_next = w_press ? S_OP : S_SHOW;
      default: w_next = w_press ? S_OP : S_INS;
    endcase
    if (w_long) begin
      w_next = S_INS;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || w_long) begin
      r_ins   <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
    end else if (w_press) begin
      if (r_state == S_OP) begin
        r_op    <= r_op_s2;
        r_valid <= 1'b1;
      end else begin
        r_ins   <= r_sw_s2;
        r_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    stage     = r_state;
    ins       = r_ins;
    op        = r_op;
    out_valid = r_valid;
  end

endmodule

// File: tb/tb_operand_entry.sv
// Directed + randomized bench for operand_entry against a
// behavioural model of the entry sequence.
module tb_operand_entry;

  localparam int DEB = 4;
  localparam int LP  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic [2:0] op_sw;
  logic       btn;
  logic [7:0] ins;
  logic [2:0] op;
  logic       out_valid;
  logic [1:0] stage;

  always #5 clk = ~clk;

  operand_entry #(
    .DEBOUNCE_CYCLES (DEB),
    .LONGPRESS_CYCLES(LP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .op_sw    (op_sw),
    .btn      (btn),
    .ins      (ins),
    .op       (op),
    .out_valid(out_valid),
    .stage    (stage)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit         lp_en;
  bit         q_btn[$];
  logic [7:0] q_sw[$];
  logic [2:0] q_op[$];
  bit         m_level;
  bit         m_prev;
  int         m_run;
  int         m_hold;
  int         m_stage;
  logic [7:0] m_ins;
  logic [2:0] m_op;
  bit         m_valid;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_btn = '{0, 0};
    q_sw  = '{8'h00, 8'h00};
    q_op  = '{3'h0, 3'h0};
    m_level = 0;
    m_prev  = 0;
    m_run   = 0;
    m_hold  = 0;
    m_stage = 0;
    m_ins   = 8'h00;
    m_op    = 3'h0;
    m_valid = 0;
  endtask

  // Pins reach the logic two edges late; a level is accepted after
  // DEB consecutive disagreeing samples; an entry steps on each press.
  task automatic model_edge();
    bit         sb;
    logic [7:0] ss;
    logic [2:0] so;
    bit         pr;
    bit         lg;
    sb = q_btn[0];
    ss = q_sw[0];
    so = q_op[0];
    pr = m_level && !m_prev;
    lg = lp_en && m_level && (m_hold == LP - 1);
    if (lg) begin
      m_ins = 0; m_op = 0; m_valid = 0; m_stage = 0;
    end else if (pr) begin
      if (m_stage == 1) begin
        m_op = so; m_valid = 1; m_stage = 2;
      end else begin
        m_ins = ss; m_valid = 0; m_stage = 1;
      end
    end
    if (!m_level)       m_hold = 0;
    else if (m_hold < LP) m_hold++;
    m_prev = m_level;
    if (sb != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = !m_level;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    q_btn.push_back(btn);   void'(q_btn.pop_front());
    q_sw.push_back(sw);     void'(q_sw.pop_front());
    q_op.push_back(op_sw);  void'(q_op.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_edge();
    #1;
    chk("cyc_ins",   ins,       m_ins);
    chk("cyc_op",    op,        m_op);
    chk("cyc_valid", out_valid, m_valid);
    chk("cyc_stage", stage,     m_stage);
  endtask

  task automatic press_release(input int hi, input int lo);
    btn = 1'b1;
    repeat (hi) tick();
    btn = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
`ifdef OPERAND_ENTRY_LONGPRESS_EN
    lp_en = 1;
`else
    lp_en = 0;
`endif
    reset = 1'b0; btn = 1'b0;
    sw = 8'h00; op_sw = 3'h0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("t1_ins",   ins,       8'h00);
    chk("t1_op",    op,        3'h0);
    chk("t1_valid", out_valid, 1'b0);
    chk("t1_stage", stage,     2'd0);

    sw = 8'h5A;
    press_release(10, 10);
    chk("t2a_stage", stage, 2'd1);
    op_sw = 3'b011;
    press_release(10, 10);
    chk("t2_ins",   ins,       8'h5A);
    chk("t2_op",    op,        3'b011);
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_stage", stage,     2'd2);

    repeat (5) begin
      btn = 1'b1; tick(); tick();
      btn = 1'b0; tick(); tick();
    end
    repeat (10) tick();
    chk("t3_ins",   ins,       8'h5A);
    chk("t3_valid", out_valid, 1'b1);
    chk("t3_stage", stage,     2'd2);

    sw = 8'hFF; op_sw = 3'b110;
    repeat (10) tick();
    chk("t4a_ins", ins, 8'h5A);
    chk("t4a_op",  op,  3'b011);
    press_release(10, 10);
    chk("t4_ins",   ins,       8'hFF);
    chk("t4_op",    op,        3'b011);
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_stage", stage,     2'd1);

    press_release(10, 10);
    chk("t5a_stage", stage, 2'd2);
    btn = 1'b1;
    repeat (7) tick();
    chk("t5b_stage", stage, 2'd1);
    reset = 1'b0; btn = 1'b0;
    tick();
    chk("t5_ins",   ins,       8'h00);
    chk("t5_op",    op,        3'h0);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_stage", stage,     2'd0);
    reset = 1'b1;
    tick();

    sw = 8'h11; op_sw = 3'b101;
    press_release(10, 10);
    press_release(10, 10);
    chk("t6a_stage", stage, 2'd2);
    sw = 8'h3C;
    btn = 1'b1;
    repeat (40) tick();
    if (lp_en) begin
      chk("t6_ins",   ins,   8'h00);
      chk("t6_op",    op,    3'h0);
      chk("t6_stage", stage, 2'd0);
    end else begin
      chk("t6_ins",   ins,   8'h3C);
      chk("t6_op",    op,    3'b101);
      chk("t6_stage", stage, 2'd1);
    end
    chk("t6_valid", out_valid, 1'b0);
    btn = 1'b0;
    repeat (10) tick();

    repeat (60) begin
      sw    = 8'($urandom);
      op_sw = 3'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          repeat ($urandom_range(4, 12)) begin
            btn = ~btn;
            repeat ($urandom_range(1, 6)) tick();
          end
          btn = 1'b0;
        end
        1: press_release($urandom_range(6, 32), 2);
        2: repeat (6) begin
          sw = 8'($urandom); op_sw = 3'($urandom);
          tick();
        end
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            reset = 1'b0; tick(); reset = 1'b1;
          end
        end
      endcase
      repeat (10) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
